// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV64I core: sequences fetch, decode, execute, memory and
// writeback over the shared datapath, counts retired instructions and latches a sticky trap.
module multicycle_controller #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            branch_taken,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            alu_src_imm,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic            trap,
  output logic [XLEN-1:0] instret
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_LOAD   = 2'b01;
  localparam logic [1:0] WB_LINK   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            trap_q, trap_d;
  logic            retire;

  logic            imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c, alu_src_imm_c;
  logic [1:0]      pc_sel_c, wb_sel_c;

  logic [6:0]      opc;
  logic            legal;
  logic            unused_instr_bits;

  assign opc   = instr[6:0];
  assign legal = (opc == OPC_OPIMM) || (opc == OPC_OP)   || (opc == OPC_AUIPC) ||
                 (opc == OPC_LOAD)  || (opc == OPC_STORE) || (opc == OPC_JAL)   ||
                 (opc == OPC_BRANCH);
  assign unused_instr_bits = ^instr[31:7];

  // The wait counter defaults to zero, so it is cleared whenever FETCH or MEM is entered.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    retire        = 1'b0;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    pc_sel_c      = PC_PLUS4;
    alu_src_imm_c = 1'b0;
    rf_we_c       = 1'b0;
    wb_sel_c      = WB_ALU;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_src_imm_c = legal && (opc != OPC_OP) && (opc != OPC_BRANCH);
        case (opc)
          OPC_BRANCH: begin
            pc_we_c  = 1'b1;
            pc_sel_c = branch_taken ? PC_BRANCH : PC_PLUS4;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OPC_LOAD, OPC_STORE:                  state_d = S_MEM;
          OPC_OP, OPC_OPIMM, OPC_AUIPC, OPC_JAL: state_d = S_WB;
          default:                              state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (opc == OPC_STORE);
        if (dmem_ack) begin
          if (opc == OPC_STORE) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            wb_sel_c = WB_LOAD;
            state_d  = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (opc == OPC_JAL) begin
          wb_sel_c = WB_LINK;
          pc_sel_c = PC_JAL;
        end else if (opc == OPC_LOAD) begin
          wb_sel_c = WB_LOAD;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    instret_d = instret_q + XLEN'(retire);
    trap_d    = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  // Gating with rst_n forces every control output low for the whole reset pulse.
  assign imem_req    = rst_n & imem_req_c;
  assign dmem_req    = rst_n & dmem_req_c;
  assign dmem_we     = rst_n & dmem_we_c;
  assign ir_we       = rst_n & ir_we_c;
  assign pc_we       = rst_n & pc_we_c;
  assign rf_we       = rst_n & rf_we_c;
  assign alu_src_imm = rst_n & alu_src_imm_c;
  assign pc_sel      = rst_n ? pc_sel_c : 2'b00;
  assign wb_sel      = rst_n ? wb_sel_c : 2'b00;
  assign trap        = trap_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instructions are
// checked cycle by cycle against schedules built from the opcode class and ack delays.
module tb_multicycle_controller;
  localparam int XLEN        = 64;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [31:0] W_ADDI = 32'h00500093;
  localparam logic [31:0] W_BEQ  = 32'h00000063;
  localparam logic [31:0] W_LD   = 32'h0000b083;
  localparam logic [31:0] W_JAL  = 32'h000000ef;
  localparam logic [31:0] W_SD   = 32'h0010b023;
  localparam logic [31:0] W_BAD  = 32'h0000007f;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [31:0]     instr = 32'h0;
  logic            branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic            imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_imm, rf_we, trap;
  logic [1:0]      pc_sel, wb_sel;
  logic [XLEN-1:0] instret;

  int              total = 0;
  int              bad = 0;
  logic [XLEN-1:0] exp_instret = '0;
  logic [6:0]      ops [7] = '{7'b0010011, 7'b0110011, 7'b0010111, 7'b0000011,
                               7'b0100011, 7'b1101111, 7'b1100011};

  always #5 clk = ~clk;

  multicycle_controller #(.XLEN(XLEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_imm(alu_src_imm), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap), .instret(instret)
  );

  function automatic logic rbit();
    return ($urandom() & 32'd1) != 32'd0;
  endfunction

  // Control vector order: imem_req dmem_req dmem_we ir_we pc_we pc_sel alu_src_imm rf_we wb_sel trap
  function automatic logic [11:0] mk(input int imem, input int dreq, input int dwe, input int irw,
                                     input int pcw, input int psel, input int alu, input int rfw,
                                     input int wsel, input int tr);
    return {imem != 0, dreq != 0, dwe != 0, irw != 0, pcw != 0, 2'(psel),
            alu != 0, rfw != 0, 2'(wsel), tr != 0};
  endfunction

  function automatic logic [11:0] outs();
    return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm, rf_we, wb_sel, trap};
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [11:0] e);
    chk({tag, "/ctl"}, XLEN'(outs()), XLEN'(e));
    chk({tag, "/instret"}, instret, exp_instret);
  endtask

  task automatic step();
    @(negedge clk);
    imem_ack     = rbit();
    dmem_ack     = rbit();
    branch_taken = rbit();
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    exp_instret = '0;
    #1;
    chk_cycle({tag, "_assert"}, 12'h0);
    repeat (2) begin
      @(negedge clk);
      imem_ack = rbit();
      dmem_ack = 1'b1;
      #1;
      chk_cycle({tag, "_hold"}, 12'h0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      instr = $urandom();
      #1;
      chk_cycle("trap_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
  endtask

  // Walks one instruction through its cycle schedule; iw/dw are ack delays in cycles.
  task automatic run_instr(input logic [31:0] word, input bit taken, input int iw, input int dw,
                           input bit abort, output bit trapped);
    logic [6:0] op;
    bit is_ld, is_st, is_br, is_jal, is_op, legal, done;
    op      = word[6:0];
    is_ld   = (op == 7'b0000011);
    is_st   = (op == 7'b0100011);
    is_br   = (op == 7'b1100011);
    is_jal  = (op == 7'b1101111);
    is_op   = (op == 7'b0110011);
    legal   = 1'b0;
    foreach (ops[i]) if (ops[i] == op) legal = 1'b1;
    trapped = 1'b0;

    done = 1'b0;
    for (int k = 0; k < MEM_TIMEOUT && !done; k++) begin
      step();
      imem_ack = (k == iw);
      #1;
      if (k == iw) begin
        chk_cycle("fetch_ack", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        done = 1'b1;
      end else begin
        chk_cycle("fetch_wait", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    if (!done) begin
      trapped = 1'b1;
      return;
    end

    step();
    instr = word;
    #1;
    chk_cycle("decode", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (!legal) begin
      trapped = 1'b1;
      return;
    end

    step();
    branch_taken = taken;
    #1;
    if (is_br) begin
      chk_cycle("exec_branch", mk(0, 0, 0, 0, 1, int'(taken), 0, 0, 0, 0));
      exp_instret = exp_instret + 64'd1;
      return;
    end
    chk_cycle("exec", mk(0, 0, 0, 0, 0, 0, int'(!is_op), 0, 0, 0));

    if (is_ld || is_st) begin
      done = 1'b0;
      for (int k = 0; k < MEM_TIMEOUT && !done; k++) begin
        step();
        dmem_ack = (k == dw);
        #1;
        if (k == dw) begin
          if (is_st) begin
            chk_cycle("mem_store_ack", mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
            exp_instret = exp_instret + 64'd1;
            return;
          end
          chk_cycle("mem_load_ack", mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
          done = 1'b1;
        end else begin
          chk_cycle("mem_wait", mk(0, 1, int'(is_st), 0, 0, 0, 0, 0, 0, 0));
          if (abort) begin
            #2;
            do_reset("abort");
            return;
          end
        end
      end
      if (!done) begin
        trapped = 1'b1;
        return;
      end
    end

    step();
    #1;
    chk_cycle("writeback", mk(0, 0, 0, 0, 1, is_jal ? 2 : 0, 0, 1,
                              is_jal ? 2 : (is_ld ? 1 : 0), 0));
    exp_instret = exp_instret + 64'd1;
  endtask

  initial begin
    bit          tr;
    bit          t;
    int          idx;
    logic [31:0] r;

    #2;
    do_reset("por");

    run_instr(W_ADDI, 1'b0, 0, 0, 1'b0, tr);
    run_instr(W_BEQ,  1'b1, 0, 0, 1'b0, tr);
    run_instr(W_BEQ,  1'b0, 0, 0, 1'b0, tr);
    run_instr(W_LD,   1'b0, 0, 3, 1'b0, tr);
    run_instr(W_JAL,  1'b0, 0, 0, 1'b0, tr);
    run_instr(W_SD,   1'b0, 1, 0, 1'b0, tr);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(6, 0);
      r   = $urandom();
      t   = rbit();
      run_instr({r[31:7], ops[idx]}, t, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0, tr);
    end

    // Ack arriving in the last permitted wait cycle still completes normally.
    run_instr(W_ADDI, 1'b0, MEM_TIMEOUT - 1, 0, 1'b0, tr);
    run_instr(W_LD,   1'b0, 0, MEM_TIMEOUT - 1, 1'b0, tr);

    run_instr(W_SD,   1'b0, 0, 2, 1'b1, tr);
    run_instr(W_ADDI, 1'b0, 0, 0, 1'b0, tr);

    run_instr(W_BAD, 1'b0, 0, 0, 1'b0, tr);
    trap_hold(8);
    do_reset("after_illegal");

    run_instr(W_ADDI, 1'b0, MEM_TIMEOUT, 0, 1'b0, tr);
    trap_hold(6);
    do_reset("after_itimeout");

    run_instr(W_LD, 1'b0, 0, MEM_TIMEOUT, 1'b0, tr);
    trap_hold(6);
    do_reset("after_dtimeout");

    run_instr(W_ADDI, 1'b0, 0, 0, 1'b0, tr);
    run_instr(W_BEQ,  1'b1, 2, 0, 1'b0, tr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
